spi_master_core: RTL and testbench

SPI controller (mode 0: CPOL=0, CPHA=0, MSB first, active-low chip select) that drives the peripheral-side SPI core used by the gray/sobel pipeline.
- A host supplies a WORD_SIZE-bit word and a start strobe.
- The block generates cs_o, sck_o and mosi_o from the system clock, shifts in miso_i, and returns the received word with a one-cycle done pulse.
- Used by on-chip test/loopback logic and as the bench driver for the peripheral core.

---
 rtl/spi_master_core.sv | 123 ++++++++++++
 tb/tb_spi_master_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// SPI mode-0 master: MSB first, active-low chip select, SCK derived from the
// system clock by a CLK_DIV divider. Sends one WORD_SIZE-bit word per start
// and returns the word shifted in on MISO with a one-cycle done pulse.
module spi_master_core #(
    parameter int WORD_SIZE = 24,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WORD_SIZE-1:0] data_tx_i,
    output logic [WORD_SIZE-1:0] data_rx_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 cs_o,
    output logic                 sck_o,
    output logic                 mosi_o,
    input  logic                 miso_i
);

    localparam int BIT_W = $clog2(WORD_SIZE + 1);
    localparam int DIV_W = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_TRANSFER,
        S_END,
        S_GAP
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_next;
    // The MSB leaves on mosi_o at load time, so only the remaining bits are held.
    logic [WORD_SIZE-2:0] tx_rest;
    logic [WORD_SIZE-1:0] rx_shift;
    logic                 tick;

    // Divider terminal count and next bit index.
    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        bit_next = bit_cnt + 1'b1;
    end

    // Transfer sequencer with registered SPI pins and host handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_rest   <= '0;
            rx_shift  <= '0;
            data_rx_o <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
            cs_o      <= 1'b1;
            sck_o     <= 1'b0;
            mosi_o    <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            // Free-running wrap; states that leave without a tick clear it explicitly.
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    if (start_i) begin
                        tx_rest <= data_tx_i[WORD_SIZE-2:0];
                        mosi_o  <= data_tx_i[WORD_SIZE-1];
                        cs_o    <= 1'b0;
                        busy_o  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tick) state <= S_TRANSFER;
                end
                S_TRANSFER: begin
                    if (tick) begin
                        sck_o <= ~sck_o;
                        if (!sck_o) begin
                            rx_shift <= {rx_shift[WORD_SIZE-2:0], miso_i};
                        end else begin
                            bit_cnt <= bit_next;
                            if (bit_next == BIT_LAST) begin
                                state <= S_END;
                            end else begin
                                mosi_o  <= tx_rest[WORD_SIZE-2];
                                tx_rest <= tx_rest << 1;
                            end
                        end
                    end
                end
                S_END: begin
                    div_cnt   <= '0;
                    done_o    <= 1'b1;
                    data_rx_o <= rx_shift;
                    if (start_i) begin
                        tx_rest <= data_tx_i[WORD_SIZE-2:0];
                        mosi_o  <= data_tx_i[WORD_SIZE-1];
                        bit_cnt <= '0;
                        state   <= S_SETUP;
                    end else begin
                        cs_o  <= 1'b1;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: table of single-word frames plus
// hand-written back-to-back, reset and CLK_DIV=1 sequences.
module tb_spi_master_core;

    localparam int W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start, done, busy, cs, sck, mosi, miso;
    logic [W-1:0] data_tx, data_rx;
    logic [1:0]   miso_mode;  // 0: const 0, 1: const 1, 2: loopback, 3: peripheral

    logic         start1, done1, busy1, cs1, sck1, mosi1;
    logic [W-1:0] data_tx1, data_rx1;

    spi_master_core #(.WORD_SIZE(W), .CLK_DIV(2)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .data_tx_i(data_tx),
        .data_rx_o(data_rx), .done_o(done), .busy_o(busy), .cs_o(cs),
        .sck_o(sck), .mosi_o(mosi), .miso_i(miso)
    );

    spi_master_core #(.WORD_SIZE(W), .CLK_DIV(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .data_tx_i(data_tx1),
        .data_rx_o(data_rx1), .done_o(done1), .busy_o(busy1), .cs_o(cs1),
        .sck_o(sck1), .mosi_o(mosi1), .miso_i(mosi1)
    );

    // Peripheral model: reply loaded on the W-th falling edge, cleared while CS high.
    logic [W-1:0] per_data_tx = 24'h5A5A5A;
    logic [W-1:0] per_tx_sr   = '0;
    logic [W-1:0] per_rx_sr   = '0;
    logic [W-1:0] per_rx_log [2];
    int unsigned  per_bits    = 0;
    int unsigned  per_rx_cnt  = 0;

    always @(posedge cs or negedge sck) begin
        if (cs) begin
            per_tx_sr <= '0;
            per_bits  <= 0;
        end else if (miso_mode == 2'd3) begin
            if (per_bits == W - 1) begin
                if (per_rx_cnt < 2) per_rx_log[per_rx_cnt] <= per_rx_sr;
                per_rx_cnt <= per_rx_cnt + 1;
                per_tx_sr  <= per_data_tx;
                per_bits   <= 0;
            end else begin
                per_tx_sr <= per_tx_sr << 1;
                per_bits  <= per_bits + 1;
            end
        end
    end

    always @(posedge sck) begin
        if (miso_mode == 2'd3 && !cs) per_rx_sr <= {per_rx_sr[W-2:0], mosi};
    end

    always_comb begin
        case (miso_mode)
            2'd0:    miso = 1'b0;
            2'd1:    miso = 1'b1;
            2'd2:    miso = mosi;
            default: miso = per_tx_sr[W-1];
        endcase
    end

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One isolated frame on dut; optional start pulse with new data at cycle pulse_at.
    task automatic run_word(input logic [W-1:0] tx, input int unsigned pulse_at,
                            output logic [W-1:0] cap_o, output int unsigned rises_o,
                            output int unsigned cs_low_o, output int unsigned dones_o,
                            output logic [W-1:0] rx_o, output int unsigned lag_o,
                            output int unsigned extra_o, output bit tmo_o);
        int unsigned cs_rise_cyc;
        logic sck_q, cs_q, busy_q;
        cs_rise_cyc = 0;
        cap_o = '0; rises_o = 0; cs_low_o = 0; dones_o = 0; rx_o = '0;
        lag_o = 0; extra_o = 0; tmo_o = 1'b1;
        sck_q = sck; cs_q = cs; busy_q = busy;
        start = 1'b1; data_tx = tx;
        for (int unsigned cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start = 1'b0; data_tx = ~tx; end
            if (pulse_at != 0 && cyc == pulse_at) begin start = 1'b1; data_tx = '1; end
            if (pulse_at != 0 && cyc == pulse_at + 1) start = 1'b0;
            if (!cs) cs_low_o++;
            if (sck && !sck_q) begin rises_o++; cap_o = {cap_o[W-2:0], mosi}; end
            if (done) begin dones_o++; rx_o = data_rx; end
            if (cs && !cs_q) cs_rise_cyc = cyc;
            if (!busy && busy_q) begin lag_o = cyc - cs_rise_cyc; tmo_o = 1'b0; end
            sck_q = sck; cs_q = cs; busy_q = busy;
            if (!tmo_o) break;
        end
        repeat (6) begin
            @(negedge clk);
            if (!cs || done || busy) extra_o++;
        end
    endtask

    typedef struct packed {
        logic [W-1:0] tx;
        logic [1:0]   mode;
        logic [W-1:0] exp_rx;
        logic [7:0]   pulse_at;
    } vec_t;

    vec_t         vecs [6];
    logic [W-1:0] cap, rx;
    logic [W-1:0] b_rx [2];
    int unsigned  rises, cs_low, dones, lag, extra, cs_rises, rise_cnt;
    bit           tmo;
    logic         sck_q, cs_q, busy_q;

    initial begin
        reset = 1'b1; start = 1'b0; data_tx = '0; miso_mode = 2'd0;
        start1 = 1'b0; data_tx1 = '0;
        repeat (2) @(negedge clk);
        check("por_cs", cs, 1); check("por_sck", sck, 0); check("por_mosi", mosi, 0);
        check("por_busy", busy, 0); check("por_done", done, 0); check("por_rx", data_rx, 0);
        reset = 1'b0;
        @(negedge clk);

        vecs[0] = '{tx: 24'h123456, mode: 2'd2, exp_rx: 24'h123456, pulse_at: 8'd0};
        vecs[1] = '{tx: 24'h0F0F0F, mode: 2'd1, exp_rx: 24'hFFFFFF, pulse_at: 8'd0};
        vecs[2] = '{tx: 24'hA5C3F0, mode: 2'd0, exp_rx: 24'h000000, pulse_at: 8'd0};
        vecs[3] = '{tx: 24'h800001, mode: 2'd2, exp_rx: 24'h800001, pulse_at: 8'd0};
        vecs[4] = '{tx: 24'h3C3C3C, mode: 2'd2, exp_rx: 24'h3C3C3C, pulse_at: 8'd30};
        vecs[5] = '{tx: 24'h000001, mode: 2'd2, exp_rx: 24'h000001, pulse_at: 8'd0};

        for (int i = 0; i < 6; i++) begin
            miso_mode = vecs[i].mode;
            run_word(vecs[i].tx, int'(vecs[i].pulse_at), cap, rises, cs_low, dones, rx, lag, extra, tmo);
            check($sformatf("v%0d_timeout", i), 32'(tmo), 0);
            check($sformatf("v%0d_mosi_bits", i), cap, vecs[i].tx);
            check($sformatf("v%0d_rises", i), rises, W);
            check($sformatf("v%0d_cs_low", i), cs_low, 99);
            check($sformatf("v%0d_dones", i), dones, 1);
            check($sformatf("v%0d_rx", i), rx, vecs[i].exp_rx);
            check($sformatf("v%0d_busy_lag", i), lag, 2);
            check($sformatf("v%0d_extra", i), extra, 0);
        end

        // Back-to-back against the peripheral model.
        miso_mode = 2'd3;
        start = 1'b1; data_tx = 24'h0000FF;
        cs_low = 0; cs_rises = 0; dones = 0; tmo = 1'b1;
        cs_q = cs; busy_q = busy;
        for (int unsigned cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) data_tx = 24'hFF0000;
            if (cyc == 100) start = 1'b0;
            if (!cs) cs_low++;
            if (cs && !cs_q) cs_rises++;
            if (done) begin
                if (dones < 2) b_rx[dones] = data_rx;
                dones++;
            end
            cs_q = cs;
            if (!busy && busy_q) begin tmo = 1'b0; break; end
            busy_q = busy;
        end
        check("b2b_timeout", 32'(tmo), 0);
        check("b2b_cs_low", cs_low, 198);
        check("b2b_cs_rises", cs_rises, 1);
        check("b2b_dones", dones, 2);
        check("b2b_rx0", b_rx[0], 24'h000000);
        check("b2b_rx1", b_rx[1], 24'h5A5A5A);
        check("b2b_per_cnt", per_rx_cnt, 2);
        check("b2b_per_rx0", per_rx_log[0], 24'h0000FF);
        check("b2b_per_rx1", per_rx_log[1], 24'hFF0000);

        // Reset held 3 cycles in the middle of a frame.
        miso_mode = 2'd2;
        start = 1'b1; data_tx = 24'hFFFFFF;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1); check("rst_sck", sck, 0); check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_rx", data_rx, 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset at bit 10 with both masters active, then a CLK_DIV=1 frame.
        start = 1'b1; data_tx = 24'h5555AA;
        start1 = 1'b1; data_tx1 = 24'hC0FFEE;
        rise_cnt = 0; sck_q = sck; tmo = 1'b1;
        for (int unsigned cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0; start1 = 1'b0;
            if (sck && !sck_q) rise_cnt++;
            sck_q = sck;
            if (rise_cnt == 10) begin tmo = 1'b0; break; end
        end
        check("bit10_timeout", 32'(tmo), 0);
        reset = 1'b1;
        @(negedge clk);
        check("bit10_cs", cs, 1); check("bit10_sck", sck, 0);
        check("bit10_cs1", cs1, 1); check("bit10_sck1", sck1, 0);
        check("bit10_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        start1 = 1'b1; data_tx1 = 24'h800001;
        cs_low = 0; dones = 0; rx = '0; lag = 0; tmo = 1'b1;
        cs_q = cs1; busy_q = busy1;
        begin
            int unsigned rise_cyc;
            rise_cyc = 0;
            for (int unsigned cyc = 1; cyc <= 200; cyc++) begin
                @(negedge clk);
                start1 = 1'b0;
                if (!cs1) cs_low++;
                if (done1) begin dones++; rx = data_rx1; end
                if (cs1 && !cs_q) rise_cyc = cyc;
                cs_q = cs1;
                if (!busy1 && busy_q) begin lag = cyc - rise_cyc; tmo = 1'b0; break; end
                busy_q = busy1;
            end
        end
        check("div1_timeout", 32'(tmo), 0);
        check("div1_cs_low", cs_low, 50);
        check("div1_dones", dones, 1);
        check("div1_rx", rx, 24'h800001);
        check("div1_busy_lag", lag, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
